// File: rtl/byte_deser_pkg.sv
// Shared types and constants for the byte deserializer slice.
// State encoding is fixed so that it is stable across builds with and
// without the BYTE_DESER_PARITY_EN option.
package byte_deser_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      PARITY = 2'b10,
      STOP   = 2'b11
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Line polarity of the framing bits: start is high, stop is low.
   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/byte_deser_shift.sv
// Shift register and bit counter for one serial frame.
// Bits land LSB first at the index held by the counter; the counter
// saturates on the last data bit so it never wraps inside a frame.
// A running XOR of the shifted bits supplies the data parity.
module byte_deser_shift
   import byte_deser_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             sdi,
   output logic [WIDTH-1:0] shreg,
   output logic [CNT_W-1:0] cnt,
   output logic             last_bit,
   output logic             parity
);

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // Capture one data bit per shift enable; clear at the start of a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg  <= '0;
         cnt    <= '0;
         parity <= 1'b0;
      end else if (clr) begin
         shreg  <= '0;
         cnt    <= '0;
         parity <= 1'b0;
      end else if (shift_en) begin
         shreg[cnt] <= sdi;
         parity     <= parity ^ sdi;
         if (!last_bit) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/byte_deserializer.sv
// Serial-to-parallel front end for the load/XOR accumulator.
// Frames: start bit, WIDTH data bits LSB first, optional odd-parity bit,
// stop bit. Each good frame updates word and pulses load for one cycle.
// Build option: define BYTE_DESER_PARITY_EN to add the parity bit and
// make par_err live; otherwise par_err is tied low.
module byte_deserializer
   import byte_deser_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sdi,
   input  logic             sen,
   output logic [WIDTH-1:0] word,
   output logic             load,
   output logic             busy,
   output logic             frame_err,
   output logic             par_err
);

   state_t           state;
   logic             clr;
   logic             shift_en;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic             last_bit;
   logic             parity;
   logic             par_good;

   byte_deser_shift #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shift_en (shift_en),
      .sdi      (sdi),
      .shreg    (shreg),
      .cnt      (cnt),
      .last_bit (last_bit),
      .parity   (parity)
   );

   // Shift-path controls derived from the current state and strobe.
   always_comb begin
      clr      = sen && (state == IDLE) && (sdi == START_BIT);
      shift_en = sen && (state == SHIFT);
   end

   assign busy = (state != IDLE);

`ifdef BYTE_DESER_PARITY_EN
   logic par_ok;

   assign par_good = par_ok;
`else
   logic unused_parity;

   assign par_good      = 1'b1;
   assign par_err       = 1'b0;
   assign unused_parity = parity;
`endif

   // Frame FSM with registered word and one-cycle status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         word      <= '0;
         load      <= 1'b0;
         frame_err <= 1'b0;
`ifdef BYTE_DESER_PARITY_EN
         par_err   <= 1'b0;
         par_ok    <= 1'b0;
`endif
      end else begin
         load      <= 1'b0;
         frame_err <= 1'b0;
`ifdef BYTE_DESER_PARITY_EN
         par_err   <= 1'b0;
`endif
         if (sen) begin
            case (state)
               IDLE: begin
                  if (sdi == START_BIT) begin
                     state <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (last_bit) begin
`ifdef BYTE_DESER_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
`ifdef BYTE_DESER_PARITY_EN
               PARITY: begin
                  // Odd parity: XOR over data and parity bit must be 1.
                  par_ok <= parity ^ sdi;
                  state  <= STOP;
               end
`endif
               STOP: begin
                  frame_err <= (sdi != STOP_BIT);
`ifdef BYTE_DESER_PARITY_EN
                  par_err   <= !par_ok;
`endif
                  if ((sdi == STOP_BIT) && par_good) begin
                     word <= shreg;
                     load <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_byte_deserializer.sv
// Scoreboard bench for byte_deserializer: a driver serialises frames and
// queues the expected outcome of each; an independent monitor compares
// every status pulse, the held word and busy against that expectation.
module tb_byte_deserializer;

`ifdef BYTE_DESER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       sdi;
   logic       sen;
   logic [7:0] word;
   logic       load;
   logic       busy;
   logic       frame_err;
   logic       par_err;

   byte_deserializer #(.WIDTH(8), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .sdi       (sdi),
      .sen       (sen),
      .word      (word),
      .load      (load),
      .busy      (busy),
      .frame_err (frame_err),
      .par_err   (par_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] word;
      logic       load;
      logic       fe;
      logic       pe;
   } ev_t;

   ev_t q[$];
   int  checks   = 0;
   int  passes   = 0;
   int  cyc      = 0;
   int  stop_cyc = -1;
   bit  exp_busy = 1'b0;
   int  gap_mode = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
   endfunction

   // One strobed bit, optionally preceded by sen=0 cycles carrying noise.
   task automatic drive_bit(input logic b, input bit busy_after);
      int g;
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (g) begin
         @(posedge clk);
         #1;
         sdi = 1'($urandom);
      end
      sdi = b;
      sen = 1'b1;
      @(posedge clk);
      #1;
      sen      = 1'b0;
      sdi      = 1'($urandom);
      exp_busy = busy_after;
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
   endtask

   // Serialise one frame and queue the outcome the rules dictate for it.
   task automatic send_frame(input logic [7:0] d, input logic stopb, input bit pflip);
      logic pb;
      ev_t  e;
      int   ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      pb = ((ones % 2) == 0) ? 1'b1 : 1'b0;
      pb = pb ^ pflip;
      drive_bit(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b1);
      if (PAR_EN) drive_bit(pb, 1'b1);
      e.word = d;
      e.fe   = (stopb != 1'b0);
      e.pe   = PAR_EN && (((ones + int'(pb)) % 2) == 0);
      e.load = !e.fe && !e.pe;
      q.push_back(e);
      drive_bit(stopb, 1'b0);
      stop_cyc = cyc;
   endtask

   task automatic pulse_reset(input int n);
      rst      = 1'b1;
      exp_busy = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   // Monitor: per-cycle comparison against the scoreboard and held state.
   initial begin
      logic       s;
      logic       pulse;
      logic       pp;
      logic [7:0] exp_word;
      logic [7:0] prev_word;
      logic       prev_busy;
      ev_t        e;
      pp        = 1'b0;
      exp_word  = '0;
      prev_word = '0;
      prev_busy = 1'b0;
      forever begin
         @(posedge clk);
         s = sen;
         cyc++;
         @(negedge clk);
         pulse = load | frame_err | par_err;
         if (rst) begin
            check("reset_outputs", 32'({word, load, busy, frame_err, par_err}), 32'd0);
            exp_word = '0;
            pulse    = 1'b0;
         end else begin
            if (!s) begin
               check("nostrobe_pulses", 32'({load, frame_err, par_err}), 32'd0);
               check("nostrobe_word", 32'(word), 32'(prev_word));
               check("nostrobe_busy", 32'(busy), 32'(prev_busy));
            end
            if (pulse) begin
               check("pulse_width", 32'(pp), 32'd0);
               check("pulse_latency", 32'(cyc), 32'(stop_cyc));
               if (q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_pulse: got load=%0b fe=%0b pe=%0b expected none",
                           load, frame_err, par_err);
               end else begin
                  e = q.pop_front();
                  check("load", 32'(load), 32'(e.load));
                  check("frame_err", 32'(frame_err), 32'(e.fe));
                  check("par_err", 32'(par_err), 32'(e.pe));
                  if (e.load) exp_word = e.word;
               end
            end
            check("word", 32'(word), 32'(exp_word));
            check("busy", 32'(busy), 32'(exp_busy));
         end
         pp        = pulse;
         prev_word = word;
         prev_busy = busy;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      sen = 1'b0;
      sdi = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      gap_mode = 0;
      idle_bits(2);
      send_frame(8'hA5, 1'b0, 1'b0);
      gap_mode = 1;
      send_frame(8'hA5, 1'b0, 1'b0);
      gap_mode = 0;
      send_frame(8'h3C, 1'b1, 1'b0);
      if (PAR_EN) begin
         send_frame(8'h0F, 1'b0, 1'b0);
         send_frame(8'h0F, 1'b0, 1'b1);
         send_frame(8'h5A, 1'b1, 1'b1);
      end
      send_frame(8'h01, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0);

      // Reset in the middle of a frame, then a clean frame afterwards.
      drive_bit(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1);
      pulse_reset(2);
      send_frame(8'hC3, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         gap_mode = int'($urandom_range(0, 2));
         idle_bits(int'($urandom_range(0, 2)));
         send_frame(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
      end

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
